// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//
// Streams a configuration bitstream, delivered as 32-bit words, into the
// serial head of a configuration flip-flop chain. Each word is
// shifted out MSB-first, one bit per cycle, with ccff_shift_en gating the
// fabric programming clock. Words accepted on the last bit of the previous
// word follow with no gap. A final partial word contributes only its upper
// bits. A load stalled in LOAD for TIMEOUT cycles without word_valid ends
// in ERROR.
//
// Ports
//   prog_clk       in   1      clock, rising edge
//   pReset         in   1      synchronous reset, active low
//   start          in   1      begin a load (from IDLE, DONE or ERROR)
//   abort          in   1      cancel the current load, return to IDLE
//   word_data      in   32     bitstream word, shifted MSB-first
//   word_valid     in   1      word_data holds a valid word
//   word_ready     out  1      word_data is accepted this cycle (combinational)
//   ccff_head      out  1      registered serial bit into the chain head
//   ccff_shift_en  out  1      registered prog-clock enable for the fabric
//   busy           out  1      load in progress (LOAD or SHIFT)
//   done           out  1      load completed
//   error          out  1      load failed on timeout
//   bit_count      out  CNT_W  bits shifted so far in this load

module ccff_bitstream_loader #(
    parameter int BITSTREAM_SIZE = 29696,
    parameter int TIMEOUT        = 1024,
    parameter int CNT_W          = 15
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      word_data,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] bit_count
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0]    SIZE_EXT  = (CNT_W + 1)'(BITSTREAM_SIZE);
    localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t            state;
    // Bit 31 of an accepted word goes straight to ccff_head, so only the
    // remaining 31 bits need to be held.
    logic [30:0]       shreg;
    logic [4:0]        bit_idx;
    logic [IDLE_W-1:0] idle_cnt;

    logic [CNT_W:0]    count_next;
    logic [IDLE_W-1:0] idle_next;
    logic              word_last;
    logic              more_bits;
    logic              accept;

    always_comb begin
        count_next = {1'b0, bit_count} + (CNT_W + 1)'(1);
        idle_next  = idle_cnt + IDLE_W'(1);
        word_last  = (bit_idx == 5'd31);
        // True while the bit currently on ccff_head is not the final one.
        more_bits  = (count_next < SIZE_EXT);
        word_ready = pReset && ((state == LOAD) ||
                                (state == SHIFT && word_last && more_bits));
        accept     = word_ready && word_valid;
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_idx       <= '0;
            idle_cnt      <= '0;
            bit_count     <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else if (abort) begin
            // Abort wins over start; bit_count is left as a record of progress.
            state         <= IDLE;
            idle_cnt      <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state     <= LOAD;
                        bit_count <= '0;
                        idle_cnt  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        shreg         <= word_data[30:0];
                        ccff_head     <= word_data[31];
                        ccff_shift_en <= 1'b1;
                        bit_idx       <= '0;
                        idle_cnt      <= '0;
                        state         <= SHIFT;
                    end else begin
                        idle_cnt <= idle_next;
                        if (idle_next == TIMEOUT_V) begin
                            state <= ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end

                SHIFT: begin
                    // The bit on ccff_head this cycle is clocked into the chain.
                    bit_count <= count_next[CNT_W-1:0];
                    if (!more_bits) begin
                        // Last stream bit; any unused low bits of the word are dropped.
                        state         <= DONE;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        ccff_shift_en <= 1'b0;
                        ccff_head     <= 1'b0;
                    end else if (word_last) begin
                        if (accept) begin
                            shreg         <= word_data[30:0];
                            ccff_head     <= word_data[31];
                            ccff_shift_en <= 1'b1;
                            bit_idx       <= '0;
                        end else begin
                            state         <= LOAD;
                            idle_cnt      <= '0;
                            ccff_shift_en <= 1'b0;
                            ccff_head     <= 1'b0;
                        end
                    end else begin
                        shreg     <= {shreg[29:0], 1'b0};
                        ccff_head <= shreg[30];
                        bit_idx   <= bit_idx + 5'd1;
                    end
                end

                default: begin
                    state         <= IDLE;
                    ccff_shift_en <= 1'b0;
                    ccff_head     <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
